e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits directly downstream of the ID/EX pipeline register and consumes that register's RS_E, RT_E and decoded IR_E operation.
- Runs multi-cycle mult/multu/div/divu and holds the architectural HI/LO registers.
- Exports `busy` so the D-stage hazard unit can stall any later HI/LO-using instruction (mfhi/mflo/mthi/mtlo/mult/div).

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (and madd/maddu). Legal range ≥1.
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu. Legal range ≥1.

Ports:
- clk  input  1  system clock; every state change happens on the rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  operation presented by the E stage. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9-15 none.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  high while a multi-cycle operation is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (synchronous): hi=0, lo=0, busy=0, cycle counter=0, state IDLE.
  - Reset asserted mid-operation aborts it; the pending result is discarded.
- States: IDLE, RUN. `busy` is a registered output, equal to (state==RUN).
- IDLE, md_op in {1,2,3,4}, or {7,8} when the optional feature is enabled, at edge k:
  - latch the operation and compute the result into internal hi_tmp/lo_tmp;
  - counter=N (N = MULT_CYCLES or DIV_CYCLES);
  - go to RUN; busy=1 from edge k.
- RUN: counter decrements each edge. At the edge where counter reaches 1 to 0: hi<=hi_tmp, lo<=lo_tmp, busy<=0, go to IDLE.
  - Net effect: busy is high for exactly N cycles, and hi/lo change at edge k+N.
- mult: {hi,lo} = signed(rs)×signed(rt), 64-bit. multu: same, unsigned.
- div/divu: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divisor 0: full DIV_CYCLES latency still runs; hi/lo keep their previous values.
- mthi/mtlo in IDLE: hi<=rs_val or lo<=rs_val at that edge; busy stays 0; single-cycle.
- Any md_op presented while busy=1 is ignored, including mthi/mtlo. The hazard unit guarantees this never happens in legal flow.
- hi/lo read paths are combinational from registers. A value written at edge k is visible during cycle k+1.
- Ops 0 and 9-15: no state change.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - md_op 7 (madd): {hi,lo} <= {hi,lo} + signed product.
  - md_op 8 (maddu): {hi,lo} <= {hi,lo} + unsigned product.
  - Both use MULT_CYCLES latency. The addend is {hi,lo} as sampled at the issue edge; the result wraps modulo 2^64.
- Not defined: md_op 7 and 8 decode as none (no state change, busy stays 0).

Test Plan:
- reset=1 for 2 cycles, then md_op=1, rs=0xFFFFFFFE (-2), rt=3:
  - busy high exactly 5 cycles;
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA after edge 5;
  - hi/lo unchanged before edge 5.
- md_op=2, rs=0xFFFFFFFE, rt=3 → hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
- md_op=3 (div):
  - rs=-7 (0xFFFFFFF9), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
  - rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu with rt=0 → busy for 10 cycles, hi/lo unchanged.
- mtlo with rs=0x12345678 in IDLE → lo=0x12345678 next cycle, busy never rises. Then start a div and, at cycle 3 of busy, drive mthi with rs=0xDEAD → ignored; the final hi is the div remainder.
- Start mult, assert reset at busy cycle 3 → busy=0, hi=lo=0 at the following edge; no later update.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then maddu rs=1, rt=1 → hi=1, lo=0 after 5 cycles.
  - Same stimulus without the macro: busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/e_mdu_if.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_if
// Brief    : E-stage to multiply/divide unit operation and HI/LO bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface e_mdu_if;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output md_op, rs_val, rt_val, input busy, hi, lo);
    modport slave  (input md_op, rs_val, rt_val, output busy, hi, lo);
endinterface
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Brief    : Multi-cycle mult/multu/div/divu unit owning HI/LO.
//            Define MDU_MADD_EN to enable madd/maddu (md_op 7/8).
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    e_mdu_if.slave    mdu
);
    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_N = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_N  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi, r_lo, r_hi_tmp, r_lo_tmp;
    logic               r_busy;

    logic [63:0] w_prod_s, w_prod_u;
    logic        w_sgn;
    logic [31:0] w_dvd, w_dvs, w_uq, w_ur, w_q, w_r;

    assign w_prod_s = $signed({{32{mdu.rs_val[31]}}, mdu.rs_val})
                    * $signed({{32{mdu.rt_val[31]}}, mdu.rt_val});
    assign w_prod_u = {32'b0, mdu.rs_val} * {32'b0, mdu.rt_val};

    // One unsigned divider serves both flavours: signed ops divide magnitudes
    // and fix up signs afterwards, which also yields 0x80000000 / -1 cleanly.
    assign w_sgn = (mdu.md_op == 4'd3);
    assign w_dvd = (w_sgn && mdu.rs_val[31]) ? -mdu.rs_val : mdu.rs_val;
    assign w_dvs = (mdu.rt_val == 32'd0) ? 32'd1
                 : ((w_sgn && mdu.rt_val[31]) ? -mdu.rt_val : mdu.rt_val);
    assign w_uq  = w_dvd / w_dvs;
    assign w_ur  = w_dvd % w_dvs;
    assign w_q   = (w_sgn && (mdu.rs_val[31] ^ mdu.rt_val[31])) ? -w_uq : w_uq;
    assign w_r   = (w_sgn && mdu.rs_val[31]) ? -w_ur : w_ur;

`ifdef MDU_MADD_EN
    logic [63:0] w_macc_s, w_macc_u;
    assign w_macc_s = {r_hi, r_lo} + w_prod_s;
    assign w_macc_u = {r_hi, r_lo} + w_prod_u;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    case (mdu.md_op)
                        4'd1, 4'd2: begin
                            {r_hi_tmp, r_lo_tmp} <= (mdu.md_op == 4'd1) ? w_prod_s : w_prod_u;
                            r_cnt   <= c_MULT_N;
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                        4'd3, 4'd4: begin
                            // Divide-by-zero still burns the full latency but
                            // commits the current HI/LO back unchanged.
                            if (mdu.rt_val == 32'd0) begin
                                r_hi_tmp <= r_hi;
                                r_lo_tmp <= r_lo;
                            end else begin
                                r_hi_tmp <= w_r;
                                r_lo_tmp <= w_q;
                            end
                            r_cnt   <= c_DIV_N;
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                        4'd5: r_hi <= mdu.rs_val;
                        4'd6: r_lo <= mdu.rs_val;
`ifdef MDU_MADD_EN
                        4'd7, 4'd8: begin
                            {r_hi_tmp, r_lo_tmp} <= (mdu.md_op == 4'd7) ? w_macc_s : w_macc_u;
                            r_cnt   <= c_MULT_N;
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                RUN: begin
                    if (r_cnt == c_ONE) begin
                        r_hi    <= r_hi_tmp;
                        r_lo    <= r_lo_tmp;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mdu.busy = r_busy;
    assign mdu.hi   = r_hi;
    assign mdu.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Brief    : Directed self-checking bench for e_mdu (default 5/10 latencies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.md_op  = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
    endtask

    // Issue an op, then expect busy for n cycles with HI/LO held at the
    // pre-values, followed by busy low and the final HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] rs, input logic [31:0] rt, input int n,
                          input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(op, rs, rt);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            check({tag, "_hold_hi"}, bus.hi, pre_hi);
            check({tag, "_hold_lo"}, bus.lo, pre_lo);
            tick();
        end
        check({tag, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div_neg7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 10,
               32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_zero", 4'd4, 32'd123, 32'd0, 10,
               32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_100_7", 4'd4, 32'd100, 32'd7, 10,
               32'h0000_0000, 32'h8000_0000, 32'd2, 32'd14);
        run_op("div_7_neg2", 4'd3, 32'd7, 32'hFFFF_FFFE, 10,
               32'd2, 32'd14, 32'd1, 32'hFFFF_FFFD);

        drive(4'd6, 32'h1234_5678, 32'd0);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        check("mtlo_lo", bus.lo, 32'h1234_5678);
        check("mtlo_hi", bus.hi, 32'd1);
        check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        check("mtlo_busy2", {31'd0, bus.busy}, 32'd0);

        // Div with an illegal mthi arriving at busy cycle 3.
        drive(4'd3, 32'hFFFF_FFF9, 32'd2);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("mthi_mid_busy", {31'd0, bus.busy}, 32'd1);
        drive(4'd5, 32'h0000_DEAD, 32'd0);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        check("mthi_ignored_hi", bus.hi, 32'd1);
        for (int i = 0; i < 7; i++) begin
            check("mthi_div_busy", {31'd0, bus.busy}, 32'd1);
            tick();
        end
        check("mthi_div_done", {31'd0, bus.busy}, 32'd0);
        check("mthi_div_hi", bus.hi, 32'hFFFF_FFFF);
        check("mthi_div_lo", bus.lo, 32'hFFFF_FFFD);

        // Reset during a mult aborts it.
        drive(4'd1, 32'd5, 32'd7);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_after_busy", {31'd0, bus.busy}, 32'd0);
            check("abort_after_hi", bus.hi, 32'd0);
            check("abort_after_lo", bus.lo, 32'd0);
        end

        drive(4'd6, 32'hFFFF_FFFF, 32'd0);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        check("madd_setup_lo", bus.lo, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", 4'd8, 32'd1, 32'd1, 5,
               32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
`else
        drive(4'd8, 32'd1, 32'd1);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("maddu_off_busy", {31'd0, bus.busy}, 32'd0);
            check("maddu_off_hi", bus.hi, 32'd0);
            check("maddu_off_lo", bus.lo, 32'hFFFF_FFFF);
            tick();
        end
`endif

        // Reserved opcode: no state change.
        drive(4'd9, 32'hAAAA_AAAA, 32'd3);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        check("op9_busy", {31'd0, bus.busy}, 32'd0);
`ifdef MDU_MADD_EN
        check("op9_hi", bus.hi, 32'd1);
        check("op9_lo", bus.lo, 32'd0);
`else
        check("op9_hi", bus.hi, 32'd0);
        check("op9_lo", bus.lo, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
